// File: rtl/psum_collector_if.sv
// ----------------------------------------------------------------------------
// psum_collector_if
//   Bundles the two handshakes of the psum collector:
//     - psum packet input from the last PE of a column (valid/ack)
//     - ofmap global-buffer write port (valid/ready)
//   Signals
//     psum_valid_in  PE -> collector  packet valid
//     psum_data_in   PE -> collector  signed psum value
//     psum_filt_in   PE -> collector  filter index of the packet
//     psum_ack_out   collector -> PE  packet taken this cycle
//     wr_valid       collector -> buf write request
//     wr_addr        collector -> buf write address {filter, out_idx}
//     wr_data        collector -> buf write data
//     wr_ready       buf -> collector write accepted
//   Modports
//     slave   the collector side
//     master  the environment side (PE column + ofmap buffer)
// ----------------------------------------------------------------------------
interface psum_collector_if #(
    parameter int PSUM_W = 12,
    parameter int ADDR_W = 8,
    parameter int FILT_W = 2
);
    logic              psum_valid_in;
    logic [PSUM_W-1:0] psum_data_in;
    logic [FILT_W-1:0] psum_filt_in;
    logic              psum_ack_out;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [PSUM_W-1:0] wr_data;
    logic              wr_ready;

    modport slave (
        input  psum_valid_in, psum_data_in, psum_filt_in, wr_ready,
        output psum_ack_out, wr_valid, wr_addr, wr_data
    );

    modport master (
        output psum_valid_in, psum_data_in, psum_filt_in, wr_ready,
        input  psum_ack_out, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/psum_collector.sv
// ----------------------------------------------------------------------------
// psum_collector
//   Sink stage at the output end of a PE column. Takes final psum packets,
//   optionally clamps negatives to zero (ReLU), tags each with its ofmap
//   address {filter, per-filter output index}, buffers it in a small FIFO and
//   writes it to the ofmap global buffer. Pulses done once all filters of the
//   tile have delivered ofmap_last+1 outputs and the FIFO has drained.
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     start         1-cycle pulse arming a new tile (ignored unless idle)
//     ofmap_last    outputs per filter minus 1, sampled on start
//     relu_en       clamp negative psums to 0, sampled on start
//     bus           psum input and ofmap write handshakes (slave side)
//     busy          collector is not idle
//     done          1-cycle pulse: tile fully written
//     error         sticky: a packet arrived for an already finished filter
// ----------------------------------------------------------------------------
module psum_collector #(
    parameter int PSUM_W     = 12,
    parameter int NUM_FILT   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-$clog2(NUM_FILT)-1:0] ofmap_last,
    input  logic                  relu_en,
    psum_collector_if.slave       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int FILT_W = $clog2(NUM_FILT);
    localparam int CNT_W  = ADDR_W - FILT_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic signed [PSUM_W-1:0] relu(
        input logic signed [PSUM_W-1:0] x,
        input logic                     en
    );
        return (en && x[PSUM_W-1]) ? '0 : x;
    endfunction

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q,     error_d;
    logic [CNT_W-1:0]    last_q;
    logic                relu_q;
    logic [CNT_W-1:0]    cnt_q [NUM_FILT];
    logic [CNT_W-1:0]    cnt_d [NUM_FILT];
    logic [NUM_FILT-1:0] filt_done_q, filt_done_d;

    // FIFO bookkeeping and storage
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W:0]      fifo_cnt_q, fifo_cnt_d;
    logic [ADDR_W-1:0]        addr_mem [FIFO_DEPTH];
    logic signed [PSUM_W-1:0] data_mem [FIFO_DEPTH];

    logic              ack;
    logic              push;
    logic              drop;
    logic              pop;
    logic [FILT_W-1:0] filt;

    assign filt = bus.psum_filt_in;

    // Ack must not look at wr_ready: a full FIFO refuses even if the head
    // is leaving this cycle, keeping the PE-side path short.
    assign ack  = bus.psum_valid_in && (state_q == COLLECT) && (fifo_cnt_q < FIFO_FULL);
    assign drop = ack &&  filt_done_q[filt];
    assign push = ack && !filt_done_q[filt];
    assign pop  = bus.wr_valid && bus.wr_ready;

    assign bus.psum_ack_out = ack;
    assign bus.wr_valid     = (fifo_cnt_q != '0);
    assign bus.wr_addr      = addr_mem[rptr_q];
    assign bus.wr_data      = data_mem[rptr_q];

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    // ------------------------------------------------------------------
    // Per-filter output counters, finish flags and overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        filt_done_d = filt_done_q;
        error_d     = error_q;
        if (state_q == IDLE && start) begin
            for (int i = 0; i < NUM_FILT; i++) begin
                cnt_d[i] = '0;
            end
            filt_done_d = '0;
            error_d     = 1'b0;
        end else if (drop) begin
            error_d = 1'b1;
        end else if (push) begin
            // The counter parks on ofmap_last so the address never wraps.
            if (cnt_q[filt] == last_q) begin
                filt_done_d[filt] = 1'b1;
            end else begin
                cnt_d[filt] = cnt_q[filt] + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tile FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            last_q      <= '0;
            relu_q      <= 1'b0;
            filt_done_q <= '0;
            for (int i = 0; i < NUM_FILT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            filt_done_q <= filt_done_d;
            error_q     <= error_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COLLECT;
                        busy_q  <= 1'b1;
                        last_q  <= ofmap_last;
                        relu_q  <= relu_en;
                    end
                end
                COLLECT: begin
                    if (&filt_done_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO pointers
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: data path only, no reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr_q] <= {filt, cnt_q[filt]};
            data_mem[wptr_q] <= relu($signed(bus.psum_data_in), relu_q);
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] ofmap_last;
    logic       relu_en;
    logic       busy;
    logic       done;
    logic       error;

    logic rdy_set;
    logic rand_en;
    logic rnd_bit;

    int errors;
    int checks;
    int done_cnt;

    logic [19:0] wq [$];

    typedef struct {
        logic [1:0]  f;
        logic [11:0] d;
        logic [7:0]  ea;
        logic [11:0] ed;
    } vec_t;

    vec_t tv [31];

    psum_collector_if #(.PSUM_W(12), .ADDR_W(8), .FILT_W(2)) bus ();

    psum_collector #(
        .PSUM_W(12), .NUM_FILT(4), .FIFO_DEPTH(4), .ADDR_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ofmap_last (ofmap_last),
        .relu_en    (relu_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    assign bus.wr_ready = rand_en ? rnd_bit : rdy_set;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Write monitor: records every completed write and every done cycle.
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.wr_valid && bus.wr_ready)
                wq.push_back({bus.wr_addr, bus.wr_data});
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        if (i < wq.size()) return {12'h0, wq[i]};
        return 32'hDEADBEEF;
    endfunction

    // All tasks below are entered and left 1 time unit after a rising edge.
    task automatic do_start(input logic [5:0] last, input logic relu);
        start      = 1'b1;
        ofmap_last = last;
        relu_en    = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [11:0] d);
        int n;
        bus.psum_valid_in = 1'b1;
        bus.psum_filt_in  = f;
        bus.psum_data_in  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.psum_ack_out) break;
            n++;
            if (n > 200) begin
                chk("ack_timeout", 32'(n), 0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.psum_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int dc0);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        chk("done_seen", 32'(done), 1);
        chk("busy_at_done", 32'(busy), 1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        @(posedge clk); #1;
        chk("done_pulses", 32'(done_cnt - dc0), 1);
    endtask

    task automatic apply(input int lo, input int hi, input int base);
        int dc0;
        dc0 = done_cnt;
        for (int i = lo; i <= hi; i++) send(tv[i].f, tv[i].d);
        wait_done(dc0);
        chk("wr_count", 32'(wq.size()), 32'(base + hi - lo + 1));
        for (int i = lo; i <= hi; i++)
            chk($sformatf("wr_%0d", i), wq_at(base + i - lo), {12'h0, tv[i].ea, tv[i].ed});
    endtask

    initial begin
        int acks;
        int n;
        int dc0;

        errors = 0;
        checks = 0;

        // test 1: relu off, 3 outputs per filter
        tv[0]  = '{2'd0, 12'h010, 8'd0,   12'h010};
        tv[1]  = '{2'd0, 12'h011, 8'd1,   12'h011};
        tv[2]  = '{2'd0, 12'hFFF, 8'd2,   12'hFFF};
        tv[3]  = '{2'd1, 12'h7FF, 8'd64,  12'h7FF};
        tv[4]  = '{2'd1, 12'h800, 8'd65,  12'h800};
        tv[5]  = '{2'd1, 12'h123, 8'd66,  12'h123};
        tv[6]  = '{2'd2, 12'hA5A, 8'd128, 12'hA5A};
        tv[7]  = '{2'd2, 12'h000, 8'd129, 12'h000};
        tv[8]  = '{2'd2, 12'h3C3, 8'd130, 12'h3C3};
        tv[9]  = '{2'd3, 12'h001, 8'd192, 12'h001};
        tv[10] = '{2'd3, 12'hF00, 8'd193, 12'hF00};
        tv[11] = '{2'd3, 12'h456, 8'd194, 12'h456};
        // test 2: relu on, 1 output per filter
        tv[12] = '{2'd0, 12'hF80, 8'd0,   12'h000};
        tv[13] = '{2'd1, 12'h07F, 8'd64,  12'h07F};
        tv[14] = '{2'd2, 12'h800, 8'd128, 12'h000};
        tv[15] = '{2'd3, 12'h001, 8'd192, 12'h001};
        // test 5: interleaved filters, 2 outputs per filter
        tv[16] = '{2'd3, 12'h301, 8'd192, 12'h301};
        tv[17] = '{2'd0, 12'h001, 8'd0,   12'h001};
        tv[18] = '{2'd3, 12'h302, 8'd193, 12'h302};
        tv[19] = '{2'd1, 12'h101, 8'd64,  12'h101};
        tv[20] = '{2'd0, 12'h002, 8'd1,   12'h002};
        tv[21] = '{2'd1, 12'h102, 8'd65,  12'h102};
        tv[22] = '{2'd2, 12'h201, 8'd128, 12'h201};
        tv[23] = '{2'd2, 12'h202, 8'd129, 12'h202};
        // test 4: remaining filters after the overflow on filter 1
        tv[24] = '{2'd0, 12'h033, 8'd0,   12'h033};
        tv[25] = '{2'd2, 12'h044, 8'd128, 12'h044};
        tv[26] = '{2'd3, 12'h055, 8'd192, 12'h055};
        // test 6: fresh tile after mid-tile reset
        tv[27] = '{2'd0, 12'h0AA, 8'd0,   12'h0AA};
        tv[28] = '{2'd1, 12'h0BB, 8'd64,  12'h0BB};
        tv[29] = '{2'd2, 12'h0CC, 8'd128, 12'h0CC};
        tv[30] = '{2'd3, 12'h0DD, 8'd192, 12'h0DD};

        // reset state, with a packet already offered
        rst = 1'b1; start = 1'b0; ofmap_last = '0; relu_en = 1'b0;
        rdy_set = 1'b1; rand_en = 1'b0;
        bus.psum_valid_in = 1'b1; bus.psum_filt_in = 2'd0; bus.psum_data_in = 12'h111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack",      32'(bus.psum_ack_out), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_error",    32'(error), 0);
        chk("rst_wr_valid", 32'(bus.wr_valid), 0);
        @(posedge clk); #1;
        bus.psum_valid_in = 1'b0;

        // test 1
        wq.delete();
        do_start(6'd2, 1'b0);
        chk("busy_after_start", 32'(busy), 1);
        apply(0, 11, 0);

        // test 2
        wq.delete();
        do_start(6'd0, 1'b1);
        apply(12, 15, 0);

        // test 3: full FIFO back-pressure
        wq.delete();
        rdy_set = 1'b0;
        dc0 = done_cnt;
        do_start(6'd5, 1'b0);
        acks = 0;
        bus.psum_valid_in = 1'b1; bus.psum_filt_in = 2'd0; bus.psum_data_in = 12'h100;
        repeat (8) begin
            @(negedge clk);
            if (bus.psum_ack_out) acks++;
            @(posedge clk); #1;
            bus.psum_data_in = 12'h100 + 12'(acks);
        end
        chk("acks_when_full", 32'(acks), 4);
        @(negedge clk);
        chk("ack_low_full",  32'(bus.psum_ack_out), 0);
        chk("hold_valid",    32'(bus.wr_valid), 1);
        chk("hold_addr",     32'(bus.wr_addr), 0);
        chk("hold_data",     32'(bus.wr_data), 32'h100);
        @(posedge clk); #1;
        rdy_set = 1'b1;
        n = 0;
        while (acks < 6 && n < 20) begin
            @(negedge clk);
            if (bus.psum_ack_out) acks++;
            @(posedge clk); #1;
            bus.psum_data_in = 12'h100 + 12'(acks);
            n++;
        end
        bus.psum_valid_in = 1'b0;
        chk("acks_resumed", 32'(acks), 6);
        for (int f = 1; f < 4; f++)
            for (int k = 0; k < 6; k++)
                send(2'(f), 12'h100 + 12'(f * 16 + k));
        wait_done(dc0);
        chk("t3_wr_count", 32'(wq.size()), 24);
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 6; k++)
                chk($sformatf("t3_wr_f%0d_%0d", f, k), wq_at(f * 6 + k),
                    {12'h0, 8'(f * 64 + k), 12'h100 + 12'(f * 16 + k)});

        // test 4: overflow on a finished filter
        wq.delete();
        do_start(6'd0, 1'b0);
        chk("error_clear_pre", 32'(error), 0);
        send(2'd1, 12'h011);
        send(2'd1, 12'h022);
        chk("error_set", 32'(error), 1);
        apply(24, 26, 1);
        chk("t4_first_wr", wq_at(0), {12'h0, 8'd64, 12'h011});
        chk("error_sticky", 32'(error), 1);

        // test 5: interleaved filters, random wr_ready
        wq.delete();
        do_start(6'd1, 1'b0);
        chk("error_cleared_by_start", 32'(error), 0);
        rand_en = 1'b1;
        apply(16, 23, 0);
        rand_en = 1'b0;

        // test 6: reset mid-tile with a full FIFO
        wq.delete();
        rdy_set = 1'b0;
        do_start(6'd2, 1'b0);
        send(2'd0, 12'h601);
        send(2'd0, 12'h602);
        send(2'd0, 12'h603);
        send(2'd1, 12'h604);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_set = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_valid", 32'(bus.wr_valid), 0);
        chk("rst_mid_busy",     32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_writes", 32'(wq.size()), 0);
        @(posedge clk); #1;
        do_start(6'd0, 1'b0);
        apply(27, 30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
